// File: rtl/maze_pkg.sv
// Shared colours, FSM state type and tower-index helper for the maze route tracker.
package maze_pkg;

    localparam logic [15:0] COL_BG     = 16'hFFFF;
    localparam logic [15:0] COL_CURSOR = 16'h93A0;
    localparam logic [15:0] COL_HIT    = 16'hFB30;

    typedef enum logic [1:0] {
        TRACK    = 2'd0,
        CUT_WAIT = 2'd1,
        DONE     = 2'd2,
        FAIL     = 2'd3
    } state_t;

    // The tower reports itself as the all-ones index of a width-bit cell number.
    function automatic logic is_tower(input logic [31:0] idx, input int width);
        logic [31:0] ones;
        ones = (32'd1 << width) - 32'd1;
        return idx == ones;
    endfunction

endpackage

// File: rtl/maze_cell_painter.sv
// Splits the cursor cell into row/column and paints the OLED pixel stream,
// registered so the colour lags x/y by exactly one clock.
module maze_cell_painter
    import maze_pkg::*;
#(
    parameter int COLS  = 18,
    parameter int IDXW  = 8,
    parameter int CELL  = 5,
    parameter int X_OFF = 0,
    parameter int Y_OFF = 10,
    parameter int FILL  = 3
)(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [6:0]      x,
    input  logic [5:0]      y,
    input  logic [IDXW-1:0] cursor_pos,
    input  logic            flash_on,
    output logic [15:0]     pixel_colour
);

    localparam logic [IDXW-1:0] COLS_W = IDXW'(COLS);

    logic [IDXW-1:0] row;
    logic [IDXW-1:0] col;
    logic [9:0]      x0;
    logic [9:0]      y0;
    logic [9:0]      px;
    logic [9:0]      py;
    logic            in_box;
    logic [15:0]     colour;

    always_comb begin
        row    = cursor_pos / COLS_W;
        col    = cursor_pos % COLS_W;
        x0     = 10'(X_OFF) + 10'(col) * 10'(CELL);
        y0     = 10'(Y_OFF) + 10'(row) * 10'(CELL);
        px     = {3'b000, x};
        py     = {4'b0000, y};
        in_box = (px >= x0) && (px < x0 + 10'(FILL)) &&
                 (py >= y0) && (py < y0 + 10'(FILL));
        colour = COL_BG;
        if (flash_on) begin
            colour = COL_HIT;
        end else if (in_box) begin
            colour = COL_CURSOR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pixel_colour <= COL_BG;
        end else begin
            pixel_colour <= colour;
        end
    end

endmodule

// File: rtl/maze_route_tracker.sv
// Maze cursor tracker with ordered checkpoints, cut-request handshake and hit flash.
// Define MAZE_STRIKE_LIMIT_EN to count hits and enter FAIL at MAX_STRIKES.
//
//   state    | meaning
//   TRACK    | following pos strobes, looking for hits and the next checkpoint
//   CUT_WAIT | cut_req held high until the cutter acknowledges
//   DONE     | every checkpoint cleared; frozen until reset
//   FAIL     | strike limit reached (strike build only); frozen until reset
module maze_route_tracker
    import maze_pkg::*;
#(
    parameter int COLS        = 18,
    parameter int ROWS        = 11,
    parameter int NCP         = 5,
    parameter int IDXW        = 8,
    parameter int START_SPOT  = 181,
    parameter int CELL        = 5,
    parameter int X_OFF       = 0,
    parameter int Y_OFF       = 10,
    parameter int FILL        = 3,
    parameter int HIT_FLASH   = 625000,
    parameter int MAX_STRIKES = 3
)(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [6:0]           x,
    input  logic [5:0]           y,
    input  logic [IDXW-1:0]      pos,
    input  logic                 pos_valid,
    input  logic [COLS*ROWS-1:0] mazestate,
    input  logic [NCP*IDXW-1:0]  cp_list,
    input  logic                 cut_ack,
    output logic [15:0]          pixel_colour,
    output logic [2:0]           wire_to_cut,
    output logic                 cut_req,
    output logic [IDXW-1:0]      begin_spot,
    output logic [2:0]           stage,
    output logic                 hit,
    output logic                 done,
    output logic                 fail
);

    localparam int         NCELL      = COLS * ROWS;
    localparam int         FW         = $clog2(HIT_FLASH + 1);
    localparam logic [2:0] LAST_STAGE = 3'(NCP - 1);

    if (NCP < 1 || NCP > 7 || (64'd1 << IDXW) <= 64'(NCELL) || MAX_STRIKES < 1) begin : g_bad_params
        $error("maze_route_tracker: illegal parameter set");
    end

    state_t          state;
    state_t          state_n;
    logic [IDXW-1:0] cursor_pos;
    logic [IDXW-1:0] cursor_n;
    logic [IDXW-1:0] begin_n;
    logic [2:0]      stage_n;
    logic [2:0]      wire_n;
    logic            cut_n;
    logic            hit_n;
    logic            done_n;
    logic [FW-1:0]   flash;
    logic [FW-1:0]   flash_n;
    logic [IDXW-1:0] cp_target;
    logic            on_path;
    logic            is_hit;

`ifdef MAZE_STRIKE_LIMIT_EN
    localparam int SW = ($clog2(MAX_STRIKES + 1) > 2) ? $clog2(MAX_STRIKES + 1) : 2;
    logic [SW-1:0] strikes;
    logic [SW-1:0] strikes_n;
    logic [SW-1:0] strikes_inc;
    logic          fail_n;
`endif

    always_comb begin
        cp_target = cp_list[stage * IDXW +: IDXW];
        on_path   = (int'(pos) < NCELL) ? mazestate[pos] : 1'b0;
        is_hit    = is_tower(32'(pos), IDXW) || (int'(pos) >= NCELL) || !on_path;
    end

    always_comb begin
        state_n  = state;
        cursor_n = cursor_pos;
        begin_n  = begin_spot;
        stage_n  = stage;
        wire_n   = wire_to_cut;
        cut_n    = cut_req;
        hit_n    = 1'b0;
        done_n   = done;
        flash_n  = (flash != '0) ? flash - 1'b1 : flash;
`ifdef MAZE_STRIKE_LIMIT_EN
        strikes_n   = strikes;
        fail_n      = fail;
        strikes_inc = (strikes == '1) ? strikes : strikes + 1'b1;
`endif
        unique case (state)
            TRACK: begin
                if (pos_valid) begin
                    if (is_hit) begin
                        hit_n    = 1'b1;
                        cursor_n = begin_spot;
                        // A new hit restarts the flash rather than extending it.
                        flash_n  = FW'(HIT_FLASH);
`ifdef MAZE_STRIKE_LIMIT_EN
                        strikes_n = strikes_inc;
                        if (32'(strikes_inc) >= MAX_STRIKES) begin
                            state_n = FAIL;
                            fail_n  = 1'b1;
                        end
`endif
                    end else if (pos == cp_target) begin
                        cursor_n = pos;
                        begin_n  = pos;
                        wire_n   = stage + 3'd1;
                        cut_n    = 1'b1;
                        state_n  = CUT_WAIT;
                    end else begin
                        cursor_n = pos;
                    end
                end
            end
            CUT_WAIT: begin
                if (cut_ack) begin
                    cut_n = 1'b0;
                    if (stage == LAST_STAGE) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        stage_n = stage + 3'd1;
                        state_n = TRACK;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= TRACK;
            cursor_pos  <= IDXW'(START_SPOT);
            begin_spot  <= IDXW'(START_SPOT);
            stage       <= 3'd0;
            wire_to_cut <= 3'd0;
            cut_req     <= 1'b0;
            hit         <= 1'b0;
            done        <= 1'b0;
            flash       <= '0;
        end else begin
            state       <= state_n;
            cursor_pos  <= cursor_n;
            begin_spot  <= begin_n;
            stage       <= stage_n;
            wire_to_cut <= wire_n;
            cut_req     <= cut_n;
            hit         <= hit_n;
            done        <= done_n;
            flash       <= flash_n;
        end
    end

`ifdef MAZE_STRIKE_LIMIT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            strikes <= '0;
            fail    <= 1'b0;
        end else begin
            strikes <= strikes_n;
            fail    <= fail_n;
        end
    end
`else
    assign fail = 1'b0;
`endif

    maze_cell_painter #(
        .COLS  (COLS),
        .IDXW  (IDXW),
        .CELL  (CELL),
        .X_OFF (X_OFF),
        .Y_OFF (Y_OFF),
        .FILL  (FILL)
    ) u_painter (
        .CLK          (CLK),
        .RESET        (RESET),
        .x            (x),
        .y            (y),
        .cursor_pos   (cursor_pos),
        .flash_on     (flash != '0),
        .pixel_colour (pixel_colour)
    );

endmodule

// File: tb/tb_maze_route_tracker.sv
// Self-checking bench for maze_route_tracker: directed table, corner sequences,
// then randomized traffic against a behavioural model of the tracker.
module tb_maze_route_tracker;

    localparam int COLS = 18, ROWS = 11, NCP = 5, IDXW = 8, START_SPOT = 181;
    localparam int CELL = 5, X_OFF = 0, Y_OFF = 10, FILL = 3, HF = 12, MAX_STRIKES = 3;
    localparam int NCELL = COLS * ROWS;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic [6:0]           x = '0;
    logic [5:0]           y = '0;
    logic [IDXW-1:0]      pos = '0;
    logic                 pos_valid = 1'b0;
    logic [NCELL-1:0]     mazestate;
    logic [NCP*IDXW-1:0]  cp_list;
    logic                 cut_ack = 1'b0;
    logic [15:0]          pixel_colour;
    logic [2:0]           wire_to_cut;
    logic                 cut_req;
    logic [IDXW-1:0]      begin_spot;
    logic [2:0]           stage;
    logic                 hit;
    logic                 done;
    logic                 fail;

    maze_route_tracker #(
        .COLS(COLS), .ROWS(ROWS), .NCP(NCP), .IDXW(IDXW), .START_SPOT(START_SPOT),
        .CELL(CELL), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .FILL(FILL),
        .HIT_FLASH(HF), .MAX_STRIKES(MAX_STRIKES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .x(x), .y(y), .pos(pos), .pos_valid(pos_valid),
        .mazestate(mazestate), .cp_list(cp_list), .cut_ack(cut_ack),
        .pixel_colour(pixel_colour), .wire_to_cut(wire_to_cut), .cut_req(cut_req),
        .begin_spot(begin_spot), .stage(stage), .hit(hit), .done(done), .fail(fail)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cps[NCP] = '{31, 113, 178, 37, 139};

    // Behavioural model: mode 0 = tracking, 1 = waiting for cutter, 2 = finished, 3 = failed.
    int          m_mode = 0, m_cursor = 0, m_begin = 0, m_stage = 0, m_wire = 0;
    int          m_flash = 0, m_strikes = 0;
    bit          m_cut = 0, m_hit = 0, m_done = 0, m_fail = 0;
    logic [15:0] m_pix = 16'hFFFF;

    function automatic bit in_cursor(int c, int px, int py);
        int r  = c / COLS;
        int k  = c % COLS;
        int x0 = X_OFF + k * CELL;
        int y0 = Y_OFF + r * CELL;
        return (px >= x0) && (px < x0 + FILL) && (py >= y0) && (py < y0 + FILL);
    endfunction

    task automatic model_step();
        int  p = int'(pos);
        bit  bad;
        m_pix = (m_flash != 0) ? 16'hFB30 :
                (in_cursor(m_cursor, int'(x), int'(y)) ? 16'h93A0 : 16'hFFFF);
        if (RESET) begin
            m_mode = 0; m_cursor = START_SPOT; m_begin = START_SPOT; m_stage = 0; m_wire = 0;
            m_flash = 0; m_strikes = 0; m_cut = 0; m_hit = 0; m_done = 0; m_fail = 0;
            m_pix = 16'hFFFF;
            return;
        end
        bad = (p == 255) || (p >= NCELL);
        if (!bad) bad = (mazestate[p] == 1'b0);
        m_hit = 0;
        if (m_flash > 0) m_flash--;
        if (m_mode == 0 && pos_valid) begin
            if (bad) begin
                m_hit = 1; m_cursor = m_begin; m_flash = HF;
`ifdef MAZE_STRIKE_LIMIT_EN
                if (m_strikes < 3) m_strikes++;
                if (m_strikes >= MAX_STRIKES) begin m_mode = 3; m_fail = 1; end
`endif
            end else if (p == cps[m_stage]) begin
                m_cursor = p; m_begin = p; m_wire = m_stage + 1; m_cut = 1; m_mode = 1;
            end else begin
                m_cursor = p;
            end
        end else if (m_mode == 1 && cut_ack) begin
            m_cut = 0;
            if (m_stage == NCP - 1) begin m_mode = 2; m_done = 1; end
            else begin m_stage++; m_mode = 0; end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        chk("model_pixel", pixel_colour, m_pix);
        chk("model_wire", wire_to_cut, m_wire);
        chk("model_cut_req", cut_req, m_cut);
        chk("model_begin", begin_spot, m_begin);
        chk("model_stage", stage, m_stage);
        chk("model_hit", hit, m_hit);
        chk("model_done", done, m_done);
        chk("model_fail", fail, m_fail);
    endtask

    task automatic drive(input bit rst, input bit pv, input int p, input bit ack,
                         input int xx, input int yy);
        RESET = rst; pos_valid = pv; pos = IDXW'(p); cut_ack = ack;
        x = 7'(xx); y = 6'(yy);
    endtask

    typedef struct {
        bit rst; bit pv; bit ack; int p; int xx; int yy;
        logic [15:0] e_pix; bit e_cut; int e_stage; int e_wire; int e_begin; bit e_hit;
    } vec_t;

    vec_t tbl[14];

    initial begin
        mazestate = '1;
        mazestate[50] = 1'b0;
        for (int k = 0; k < NCP; k++) cp_list[k*IDXW +: IDXW] = IDXW'(cps[k]);

        tbl[0]  = '{1, 0, 0, 0,   0,  10, 16'hFFFF, 0, 0, 0, 181, 0};
        tbl[1]  = '{0, 0, 0, 0,   0,  10, 16'hFFFF, 0, 0, 0, 181, 0};
        tbl[2]  = '{0, 0, 0, 0,   5,  60, 16'h93A0, 0, 0, 0, 181, 0};
        tbl[3]  = '{0, 0, 0, 0,   8,  60, 16'hFFFF, 0, 0, 0, 181, 0};
        tbl[4]  = '{0, 1, 0, 180, 0,  60, 16'hFFFF, 0, 0, 0, 181, 0};
        tbl[5]  = '{0, 0, 0, 0,   0,  60, 16'h93A0, 0, 0, 0, 181, 0};
        tbl[6]  = '{0, 0, 0, 0,   0,  63, 16'hFFFF, 0, 0, 0, 181, 0};
        tbl[7]  = '{0, 1, 0, 113, 0,  0,  16'hFFFF, 0, 0, 0, 181, 0};
        tbl[8]  = '{0, 0, 0, 0,   27, 42, 16'h93A0, 0, 0, 0, 181, 0};
        tbl[9]  = '{0, 1, 0, 31,  0,  0,  16'hFFFF, 1, 0, 1, 31,  0};
        tbl[10] = '{0, 1, 0, 50,  65, 15, 16'h93A0, 1, 0, 1, 31,  0};
        tbl[11] = '{0, 0, 1, 0,   0,  0,  16'hFFFF, 0, 1, 1, 31,  0};
        tbl[12] = '{0, 1, 0, 255, 0,  0,  16'hFFFF, 0, 1, 1, 31,  1};
        tbl[13] = '{0, 0, 0, 0,   0,  0,  16'hFB30, 0, 1, 1, 31,  0};

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].pv, tbl[i].p, tbl[i].ack, tbl[i].xx, tbl[i].yy);
            step();
            chk($sformatf("tbl%0d_pix", i), pixel_colour, tbl[i].e_pix);
            chk($sformatf("tbl%0d_cut", i), cut_req, tbl[i].e_cut);
            chk($sformatf("tbl%0d_stage", i), stage, tbl[i].e_stage);
            chk($sformatf("tbl%0d_wire", i), wire_to_cut, tbl[i].e_wire);
            chk($sformatf("tbl%0d_begin", i), begin_spot, tbl[i].e_begin);
            chk($sformatf("tbl%0d_hit", i), hit, tbl[i].e_hit);
        end

        // Flash lasts exactly HF pixels after the hit; the first was seen in the table.
        for (int i = 0; i < HF - 1; i++) begin
            drive(0, 0, 0, 0, 65, 15);
            step();
            chk("flash_on", pixel_colour, 16'hFB30);
        end
        drive(0, 0, 0, 0, 65, 15);
        step();
        chk("flash_end_respawn", pixel_colour, 16'h93A0);

        // Wall and out-of-range cells are hits; an out-of-order checkpoint is plain path.
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 50, 0, 0, 0); step(); chk("wall_hit", hit, 1);
        drive(0, 0, 0, 0, 0, 0);  step(); chk("hit_pulse_len", hit, 0);
        drive(0, 1, 200, 0, 0, 0); step(); chk("range_hit", hit, 1);
        drive(0, 1, 113, 0, 0, 0); step(); chk("ooo_cp_no_cut", cut_req, 0);

        // Full ordered run to DONE.
        drive(1, 0, 0, 0, 0, 0); step();
        for (int k = 0; k < NCP; k++) begin
            drive(0, 1, cps[k], 0, 0, 0); step();
            chk("seq_cut_req", cut_req, 1);
            chk("seq_wire", wire_to_cut, k + 1);
            drive(0, 0, 0, 1, 0, 0); step();
            chk("seq_cut_drop", cut_req, 0);
            chk("seq_stage", stage, (k < NCP - 1) ? k + 1 : NCP - 1);
        end
        chk("seq_done", done, 1);
        drive(0, 1, 255, 0, 0, 0); step(); chk("done_ignores_pos", hit, 0);
        drive(0, 1, 50, 1, 0, 0);  step(); chk("done_frozen_wire", wire_to_cut, 5);

        // Strike limit (or its absence), then reset in the middle of a cut request.
        drive(1, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 255, 0, 0, 0); step();
            chk("strike_hit", hit, 1);
`ifdef MAZE_STRIKE_LIMIT_EN
            chk("strike_fail", fail, (i == 2) ? 1 : 0);
`else
            chk("strike_fail", fail, 0);
`endif
            drive(0, 0, 0, 0, 0, 0); step();
        end
        drive(0, 1, 31, 0, 0, 0); step();
`ifdef MAZE_STRIKE_LIMIT_EN
        chk("fail_ignores_pos", cut_req, 0);
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 31, 0, 0, 0); step();
`endif
        chk("cut_before_reset", cut_req, 1);
        drive(1, 0, 0, 1, 0, 0); step();
        chk("rst_cut_req", cut_req, 0);
        chk("rst_stage", stage, 0);
        chk("rst_wire", wire_to_cut, 0);
        chk("rst_begin", begin_spot, START_SPOT);
        chk("rst_pix", pixel_colour, 16'hFFFF);
        chk("rst_fail", fail, 0);

        // Randomized traffic on a random maze; checkpoint cells stay on the path.
        for (int b = 0; b < NCELL; b++) mazestate[b] = ($urandom_range(0, 4) != 0);
        for (int k = 0; k < NCP; k++) mazestate[cps[k]] = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            int r, p, xx, yy;
            r = $urandom_range(0, 9);
            if (r <= 2)      p = cps[(m_stage < NCP) ? m_stage : 0];
            else if (r == 3) p = 255;
            else if (r == 4) p = $urandom_range(NCELL, 254);
            else if (r == 5) p = cps[$urandom_range(0, NCP - 1)];
            else             p = $urandom_range(0, NCELL - 1);
            if ($urandom_range(0, 1) == 1) begin
                xx = X_OFF + (m_cursor % COLS) * CELL + $urandom_range(0, 4) - 1;
                yy = Y_OFF + (m_cursor / COLS) * CELL + $urandom_range(0, 4) - 1;
            end else begin
                xx = $urandom_range(0, 127);
                yy = $urandom_range(0, 63);
            end
            if (xx < 0) xx = 0;
            if (yy < 0) yy = 0;
            if (yy > 63) yy = 63;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, p,
                  $urandom_range(0, 3) == 0, xx, yy);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
